// File: rtl/char_buffer_writer_if.sv
// Byte-stream handshake, screen-memory port and cursor/status signals of char_buffer_writer.
// slave is the writer itself; master is whatever drives bytes and models the memory.
interface char_buffer_writer_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] mem_raddr;
  logic [7:0]  mem_rdata;
  logic [10:0] mem_waddr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [4:0]  cur_row;
  logic [6:0]  cur_col;
  logic        busy;

  modport slave (
    input  in_data, in_valid, mem_rdata,
    output in_ready, mem_raddr, mem_waddr, mem_wdata, mem_we, cur_row, cur_col, busy
  );

  modport master (
    output in_data, in_valid, mem_rdata,
    input  in_ready, mem_raddr, mem_waddr, mem_wdata, mem_we, cur_row, cur_col, busy
  );
endinterface

// File: rtl/char_buffer_writer.sv
// Terminal-style writer for the 80x25 ASCII screen memory: prints bytes, moves the cursor,
// scrolls on LF at the bottom row and clears the screen on FF.
module char_buffer_writer #(
  parameter int unsigned COLS  = 80,
  parameter int unsigned ROWS  = 25,
  parameter logic [7:0]  BLANK = 8'h20
) (
  input  logic                 clk,
  input  logic                 clr_n,
  char_buffer_writer_if.slave  bus
);

  // SCROLL_WORDS is both the last scroll cycle index and the base address of the bottom line.
  localparam logic [10:0] LINE_WORDS   = 11'(COLS);
  localparam logic [10:0] SCROLL_WORDS = 11'(COLS * (ROWS - 1));
  localparam logic [10:0] LINE_LAST    = 11'(COLS - 1);
  localparam logic [10:0] SCREEN_LAST  = 11'(COLS * ROWS - 1);
  localparam logic [6:0]  COL_MAX      = 7'(COLS - 1);
  localparam logic [4:0]  ROW_MAX      = 5'(ROWS - 1);

  localparam logic [7:0] CH_BS  = 8'h08;
  localparam logic [7:0] CH_TAB = 8'h09;
  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_FF  = 8'h0C;
  localparam logic [7:0] CH_CR  = 8'h0D;

  typedef enum logic [1:0] {IDLE, SCROLL, CLEAR_LINE, CLEAR_ALL} state_e;

  state_e      state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic [4:0]  row_q, row_d;
  logic [6:0]  col_q, col_d;
  logic        in_ready_q, in_ready_d;
  logic [10:0] raddr_q, raddr_d;
  logic        pend_we_q, pend_we_d;
  logic [10:0] pend_addr_q, pend_addr_d;
  logic [7:0]  pend_data_q, pend_data_d;

  logic        accept;
  logic [10:0] cur_addr;
  logic [6:0]  tab_col;

  function automatic logic is_printable(input logic [7:0] b);
    return ((b >= 8'h20) && (b <= 8'h7E)) || (b >= 8'hA0);
  endfunction

  assign accept   = bus.in_valid && in_ready_q;
  assign cur_addr = 11'(row_q) * LINE_WORDS + 11'(col_q);
  assign tab_col  = {col_q[6:3] + 4'd1, 3'b000};

  // State register
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      row_q       <= '0;
      col_q       <= '0;
      in_ready_q  <= 1'b0;
      raddr_q     <= '0;
      pend_we_q   <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values of all the others.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      row_q       <= row_d;
      col_q       <= col_d;
      in_ready_q  <= in_ready_d;
      raddr_q     <= raddr_d;
      pend_we_q   <= pend_we_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: every variable gets a default first so no branch can leave it unassigned (no latch).
    state_d     = state_q;
    cnt_d       = cnt_q;
    row_d       = row_q;
    col_d       = col_q;
    raddr_d     = raddr_q;
    pend_we_d   = 1'b0;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d = '0;
          if (is_printable(bus.in_data)) begin
            pend_we_d   = 1'b1;
            pend_addr_d = cur_addr;
            pend_data_d = bus.in_data;
            if (col_q != COL_MAX) col_d = col_q + 7'd1;
          end else begin
            case (bus.in_data)
              CH_CR:  col_d = '0;
              CH_BS:  if (col_q != '0) col_d = col_q - 7'd1;
              CH_TAB: col_d = (tab_col > COL_MAX) ? COL_MAX : tab_col;
              CH_LF: begin
                if (row_q != ROW_MAX) begin
                  row_d = row_q + 5'd1;
                end else begin
                  state_d = SCROLL;
                  raddr_d = LINE_WORDS;
                end
              end
              CH_FF:   state_d = CLEAR_ALL;
              default: ;
            endcase
          end
        end
      end

      // Read runs one cycle ahead of the write that consumes its data; the read address
      // stops on the last source word and then holds.
      SCROLL: begin
        if (cnt_q < SCROLL_WORDS - 11'd1) raddr_d = raddr_q + 11'd1;
        if (cnt_q == SCROLL_WORDS) begin
          state_d = CLEAR_LINE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end

      CLEAR_LINE: begin
        if (cnt_q == LINE_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end

      CLEAR_ALL: begin
        if (cnt_q == SCREEN_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          row_d   = '0;
          col_d   = '0;
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end

      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == IDLE) && !accept;
  end

  // Output logic
  always_comb begin
    bus.mem_we    = pend_we_q;
    bus.mem_waddr = pend_addr_q;
    bus.mem_wdata = pend_data_q;

    unique case (state_q)
      SCROLL: begin
        if (cnt_q != '0) begin
          bus.mem_we    = 1'b1;
          bus.mem_waddr = cnt_q - 11'd1;
          bus.mem_wdata = bus.mem_rdata;
        end
      end
      CLEAR_LINE: begin
        bus.mem_we    = 1'b1;
        bus.mem_waddr = SCROLL_WORDS + cnt_q;
        bus.mem_wdata = BLANK;
      end
      CLEAR_ALL: begin
        bus.mem_we    = 1'b1;
        bus.mem_waddr = cnt_q;
        bus.mem_wdata = BLANK;
      end
      default: ;
    endcase
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mem_raddr = raddr_q;
  assign bus.cur_row   = row_q;
  assign bus.cur_col   = col_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_char_buffer_writer.sv
// Bench for char_buffer_writer: directed scenarios plus a random byte stream, checked against
// a screen/cursor reference model and a one-cycle-latency screen memory model.
module tb_char_buffer_writer;
  localparam int COLS  = 80;
  localparam int ROWS  = 25;
  localparam int WORDS = COLS * ROWS;
  localparam logic [7:0] BLANK = 8'h20;
  localparam logic [7:0] BS  = 8'h08;
  localparam logic [7:0] TAB = 8'h09;
  localparam logic [7:0] LF  = 8'h0A;
  localparam logic [7:0] FF  = 8'h0C;
  localparam logic [7:0] CR  = 8'h0D;

  logic clk   = 1'b0;
  logic clr_n = 1'b0;
  int   n_run  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  char_buffer_writer_if bus ();

  char_buffer_writer #(.COLS(COLS), .ROWS(ROWS), .BLANK(BLANK)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  function automatic logic [7:0] pat(input int n);
    return 8'((n * 7) ^ (n >> 4) ^ 8'h5A);
  endfunction

  // Screen memory model: synchronous read, one write per cycle, bulk fill for preloads.
  logic [7:0] mem [WORDS];
  logic [7:0] rdata_q;
  logic [1:0] fill_mode = 2'd0;

  assign bus.mem_rdata = rdata_q;

  // NOTE: the screen memory is not reset; its contents survive clr_n and are only filled on request.
  always @(posedge clk) begin
    if (fill_mode != 2'd0) begin
      for (int n = 0; n < WORDS; n++) mem[n] <= (fill_mode == 2'd1) ? BLANK : pat(n);
    end else if (bus.mem_we === 1'b1 && int'(bus.mem_waddr) < WORDS) begin
      mem[bus.mem_waddr] <= bus.mem_wdata;
    end
    rdata_q <= (int'(bus.mem_raddr) < WORDS) ? mem[bus.mem_raddr] : 8'h00;
  end

  int         wlog_addr [$];
  logic [7:0] wlog_data [$];

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wlog_addr.push_back(int'(bus.mem_waddr));
      wlog_data.push_back(bus.mem_wdata);
    end
  end

  // Reference model: screen contents and cursor as a terminal would keep them.
  logic [7:0] ref_mem [WORDS];
  int ref_row = 0;
  int ref_col = 0;

  function automatic bit printable(input logic [7:0] b);
    return (b >= 8'h20 && b <= 8'h7E) || (b >= 8'hA0);
  endfunction

  task automatic ref_apply(input logic [7:0] b);
    if (printable(b)) begin
      ref_mem[ref_row * COLS + ref_col] = b;
      if (ref_col < COLS - 1) ref_col++;
    end else if (b == CR) begin
      ref_col = 0;
    end else if (b == BS) begin
      if (ref_col > 0) ref_col--;
    end else if (b == TAB) begin
      ref_col = (ref_col / 8 + 1) * 8;
      if (ref_col > COLS - 1) ref_col = COLS - 1;
    end else if (b == LF) begin
      if (ref_row < ROWS - 1) ref_row++;
      else begin
        for (int n = 0; n < WORDS - COLS; n++) ref_mem[n] = ref_mem[n + COLS];
        for (int n = WORDS - COLS; n < WORDS; n++) ref_mem[n] = BLANK;
      end
    end else if (b == FF) begin
      for (int n = 0; n < WORDS; n++) ref_mem[n] = BLANK;
      ref_row = 0;
      ref_col = 0;
    end
  endtask

  task automatic preload(input logic [1:0] mode);
    @(negedge clk) fill_mode = mode;
    @(negedge clk) fill_mode = 2'd0;
    for (int n = 0; n < WORDS; n++) ref_mem[n] = (mode == 2'd1) ? BLANK : pat(n);
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (bus.in_ready !== 1'b1) begin
      n_run++; n_fail++;
      $display("FAIL wait_idle: in_ready=%b after %0d cycles, required 1", bus.in_ready, guard);
    end
  endtask

  // Returns at the falling edge of the cycle after the byte was accepted.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    wait_idle();
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    ref_apply(b);
  endtask

  task automatic goto_cursor(input int r, input int c);
    if (ref_row > r) send_byte(FF);
    while (ref_row < r) send_byte(LF);
    while (ref_col < c) send_byte(TAB);
    while (ref_col > c) send_byte(BS);
    wait_idle();
  endtask

  function automatic logic [7:0] rand_byte();
    int unsigned r;
    r = $urandom_range(0, 99);
    if (r < 55) begin
      if ($urandom_range(0, 1) == 0) return 8'($urandom_range(32'h20, 32'h7E));
      return 8'($urandom_range(32'hA0, 32'hFF));
    end
    if (r < 64) return CR;
    if (r < 72) return BS;
    if (r < 80) return TAB;
    if (r < 88) return LF;
    if (r < 89) return FF;
    if ($urandom_range(0, 1) == 0) return 8'($urandom_range(0, 31));
    return 8'($urandom_range(32'h7F, 32'h9F));
  endfunction

  task automatic test_reset();
    logic [44:0] outs;
    repeat (3) @(negedge clk);
    outs = {bus.in_ready, bus.busy, bus.mem_we, bus.mem_raddr, bus.mem_waddr, bus.mem_wdata,
            bus.cur_row, bus.cur_col};
    n_run++;
    if (outs !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h, required 0", outs);
    end
    clr_n = 1'b1;
    #1;
    n_run++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready_before_edge: got %b, required 0", bus.in_ready);
    end
    @(negedge clk);
    n_run++;
    if ({bus.in_ready, bus.busy} !== 2'b10) begin
      n_fail++; $display("FAIL reset_ready_after_edge: ready/busy got %b, required 10", {bus.in_ready, bus.busy});
    end
  endtask

  task automatic test_print_a();
    send_byte(8'h41);
    n_run++;
    if ({bus.mem_we, bus.mem_waddr, bus.mem_wdata} !== {1'b1, 11'd0, 8'h41}) begin
      n_fail++; $display("FAIL print_a_write: we=%b addr=%0d data=%h, required 1/0/41",
                         bus.mem_we, bus.mem_waddr, bus.mem_wdata);
    end
    n_run++;
    if ({bus.cur_row, bus.cur_col, bus.in_ready} !== {5'd0, 7'd1, 1'b0}) begin
      n_fail++; $display("FAIL print_a_cursor: row=%0d col=%0d ready=%b, required 0/1/0",
                         bus.cur_row, bus.cur_col, bus.in_ready);
    end
    @(negedge clk);
    n_run++;
    if ({bus.in_ready, bus.mem_we} !== 2'b10) begin
      n_fail++; $display("FAIL print_a_ready_back: ready/we got %b, required 10", {bus.in_ready, bus.mem_we});
    end
  endtask

  task automatic test_no_wrap();
    logic [7:0] chars [3];
    int         addrs [3];
    chars = '{8'h78, 8'h79, 8'h7A};
    addrs = '{318, 319, 319};
    goto_cursor(3, 78);
    for (int i = 0; i < 3; i++) begin
      send_byte(chars[i]);
      n_run++;
      if ({bus.mem_we, bus.mem_waddr, bus.mem_wdata} !== {1'b1, 11'(addrs[i]), chars[i]}) begin
        n_fail++; $display("FAIL no_wrap_write%0d: we=%b addr=%0d data=%h, required 1/%0d/%h",
                           i, bus.mem_we, bus.mem_waddr, bus.mem_wdata, addrs[i], chars[i]);
      end
    end
    wait_idle();
    n_run++;
    if ({bus.cur_row, bus.cur_col} !== {5'd3, 7'd79}) begin
      n_fail++; $display("FAIL no_wrap_cursor: row=%0d col=%0d, required 3/79", bus.cur_row, bus.cur_col);
    end
  endtask

  task automatic test_tab_bs_cr();
    logic [7:0] seq [3];
    int         cols [3];
    int         base;
    seq  = '{TAB, BS, CR};
    cols = '{16, 15, 0};
    goto_cursor(5, 10);
    base = wlog_addr.size();
    for (int i = 0; i < 3; i++) begin
      send_byte(seq[i]);
      wait_idle();
      n_run++;
      if ({bus.cur_row, bus.cur_col} !== {5'd5, 7'(cols[i])}) begin
        n_fail++; $display("FAIL tab_bs_cr_step%0d: row=%0d col=%0d, required 5/%0d",
                           i, bus.cur_row, bus.cur_col, cols[i]);
      end
    end
    @(negedge clk);
    n_run++;
    if (wlog_addr.size() != base) begin
      n_fail++; $display("FAIL tab_bs_cr_writes: got %0d writes, required 0", wlog_addr.size() - base);
    end
  endtask

  task automatic test_scroll();
    int base, busy_cycles, bad_ready, bad_log, bad_mem;
    logic [7:0] exp_d;
    goto_cursor(24, 0);
    preload(2'd2);
    base = wlog_addr.size();
    send_byte(LF);
    busy_cycles = 0;
    bad_ready   = 0;
    while (bus.busy === 1'b1 && busy_cycles < 5000) begin
      if (bus.in_ready !== 1'b0) bad_ready++;
      busy_cycles++;
      @(negedge clk);
    end
    n_run++;
    if (busy_cycles != 2001 || bad_ready != 0) begin
      n_fail++; $display("FAIL scroll_busy: busy %0d cycles with %0d ready-high, required 2001 and 0",
                         busy_cycles, bad_ready);
    end
    n_run++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL scroll_ready_return: got %b, required 1", bus.in_ready);
    end
    bad_log = 0;
    if (wlog_addr.size() - base != WORDS) bad_log++;
    else begin
      for (int i = 0; i < WORDS; i++) begin
        exp_d = (i < WORDS - COLS) ? pat(i + COLS) : BLANK;
        if (wlog_addr[base + i] != i || wlog_data[base + i] !== exp_d) bad_log++;
      end
    end
    n_run++;
    if (bad_log != 0) begin
      n_fail++; $display("FAIL scroll_write_seq: %0d bad entries in %0d writes, required 0 bad in %0d",
                         bad_log, wlog_addr.size() - base, WORDS);
    end
    bad_mem = 0;
    for (int n = 0; n < WORDS; n++) if (mem[n] !== ref_mem[n]) bad_mem++;
    n_run++;
    if (bad_mem != 0) begin
      n_fail++; $display("FAIL scroll_memory: %0d words differ, required 0", bad_mem);
    end
    n_run++;
    if ({bus.cur_row, bus.cur_col} !== {5'd24, 7'd0}) begin
      n_fail++; $display("FAIL scroll_cursor: row=%0d col=%0d, required 24/0", bus.cur_row, bus.cur_col);
    end
  endtask

  task automatic test_clear_all();
    int base, busy_cycles, bad_ready, bad_log, bad_mem;
    goto_cursor(12, 40);
    base = wlog_addr.size();
    send_byte(FF);
    bus.in_data  = 8'h51;
    bus.in_valid = 1'b1;
    n_run++;
    if ({bus.cur_row, bus.cur_col} !== {5'd12, 7'd40}) begin
      n_fail++; $display("FAIL clear_cursor_during: row=%0d col=%0d, required 12/40", bus.cur_row, bus.cur_col);
    end
    busy_cycles = 0;
    bad_ready   = 0;
    while (bus.busy === 1'b1 && busy_cycles < 5000) begin
      if (bus.in_ready !== 1'b0) bad_ready++;
      busy_cycles++;
      @(negedge clk);
    end
    n_run++;
    if (busy_cycles != 2000 || bad_ready != 0) begin
      n_fail++; $display("FAIL clear_busy: busy %0d cycles with %0d ready-high, required 2000 and 0",
                         busy_cycles, bad_ready);
    end
    n_run++;
    if ({bus.in_ready, bus.cur_row, bus.cur_col} !== {1'b1, 5'd0, 7'd0}) begin
      n_fail++; $display("FAIL clear_done: ready=%b row=%0d col=%0d, required 1/0/0",
                         bus.in_ready, bus.cur_row, bus.cur_col);
    end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    ref_apply(8'h51);
    n_run++;
    if ({bus.mem_we, bus.mem_waddr, bus.mem_wdata, bus.cur_col} !== {1'b1, 11'd0, 8'h51, 7'd1}) begin
      n_fail++; $display("FAIL clear_held_byte: we=%b addr=%0d data=%h col=%0d, required 1/0/51/1",
                         bus.mem_we, bus.mem_waddr, bus.mem_wdata, bus.cur_col);
    end
    @(negedge clk);
    bad_log = 0;
    if (wlog_addr.size() - base != WORDS + 1) bad_log++;
    else begin
      for (int i = 0; i < WORDS; i++)
        if (wlog_addr[base + i] != i || wlog_data[base + i] !== BLANK) bad_log++;
    end
    n_run++;
    if (bad_log != 0) begin
      n_fail++; $display("FAIL clear_write_seq: %0d bad entries in %0d writes, required 0 bad in %0d",
                         bad_log, wlog_addr.size() - base, WORDS + 1);
    end
    bad_mem = 0;
    for (int n = 0; n < WORDS; n++) if (mem[n] !== ref_mem[n]) bad_mem++;
    n_run++;
    if (bad_mem != 0) begin
      n_fail++; $display("FAIL clear_memory: %0d words differ, required 0", bad_mem);
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    int exp_addr, bad_mem;
    bit pr;
    for (int i = 0; i < 300; i++) begin
      b        = rand_byte();
      pr       = printable(b);
      exp_addr = ref_row * COLS + ref_col;
      send_byte(b);
      if (pr) begin
        n_run++;
        if ({bus.mem_we, bus.mem_waddr, bus.mem_wdata} !== {1'b1, 11'(exp_addr), b}) begin
          n_fail++; $display("FAIL random_write%0d: we=%b addr=%0d data=%h, required 1/%0d/%h",
                             i, bus.mem_we, bus.mem_waddr, bus.mem_wdata, exp_addr, b);
        end
      end
      wait_idle();
      n_run++;
      if ({bus.cur_row, bus.cur_col} !== {5'(ref_row), 7'(ref_col)}) begin
        n_fail++; $display("FAIL random_cursor%0d: byte %h row=%0d col=%0d, required %0d/%0d",
                           i, b, bus.cur_row, bus.cur_col, ref_row, ref_col);
      end
    end
    bad_mem = 0;
    for (int n = 0; n < WORDS; n++) if (mem[n] !== ref_mem[n]) bad_mem++;
    n_run++;
    if (bad_mem != 0) begin
      n_fail++; $display("FAIL random_memory: %0d words differ, required 0", bad_mem);
    end
  endtask

  task automatic test_reset_mid_scroll();
    logic [44:0] outs;
    int base;
    goto_cursor(24, 5);
    send_byte(LF);
    repeat (700) @(negedge clk);
    n_run++;
    if (bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL midreset_busy_before: got %b, required 1", bus.busy);
    end
    #2 clr_n = 1'b0;
    #1;
    outs = {bus.in_ready, bus.busy, bus.mem_we, bus.mem_raddr, bus.mem_waddr, bus.mem_wdata,
            bus.cur_row, bus.cur_col};
    n_run++;
    if (outs !== '0) begin
      n_fail++; $display("FAIL midreset_outputs: got %h, required 0", outs);
    end
    base = wlog_addr.size();
    @(negedge clk);
    clr_n = 1'b1;
    #1;
    n_run++;
    if ({bus.busy, bus.in_ready} !== 2'b00) begin
      n_fail++; $display("FAIL midreset_release: busy/ready got %b, required 00", {bus.busy, bus.in_ready});
    end
    @(negedge clk);
    @(negedge clk);
    n_run++;
    if ({bus.busy, bus.in_ready, bus.mem_we} !== 3'b010 || wlog_addr.size() != base) begin
      n_fail++; $display("FAIL midreset_idle: busy/ready/we got %b with %0d writes, required 010 and 0",
                         {bus.busy, bus.in_ready, bus.mem_we}, wlog_addr.size() - base);
    end
    for (int n = 0; n < WORDS; n++) ref_mem[n] = mem[n];
    ref_row = 0;
    ref_col = 0;
    send_byte(8'h5A);
    n_run++;
    if ({bus.mem_we, bus.mem_waddr, bus.mem_wdata, bus.cur_row, bus.cur_col} !==
        {1'b1, 11'd0, 8'h5A, 5'd0, 7'd1}) begin
      n_fail++; $display("FAIL midreset_first_byte: we=%b addr=%0d data=%h row=%0d col=%0d, required 1/0/5a/0/1",
                         bus.mem_we, bus.mem_waddr, bus.mem_wdata, bus.cur_row, bus.cur_col);
    end
  endtask

  initial begin
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    preload(2'd1);
    test_reset();
    test_print_a();
    test_no_wrap();
    test_tab_bs_cr();
    test_scroll();
    test_clear_all();
    test_random();
    test_reset_mid_scroll();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/char_buffer_writer.md
Name: char_buffer_writer

Overview:
- Write-side companion to the video scan-out, which reads the 80x25 ASCII screen memory.
- Accepts a byte stream (e.g. from a UART receiver) over a valid/ready handshake and maintains the cursor.
- Writes printable characters into screen memory and executes CR, LF, BS, TAB and FF.
- When LF is received on the bottom row, scrolls the screen by copying memory upward, then blanks the bottom line.

Parameters:
- COLS, 80, characters per row.
- ROWS, 25, rows per screen.
- BLANK, 8'h20, fill byte used for line and screen clears.

Ports:
- clk  in  1  system (pixel PLL) clock.
- clr_n  in  1  asynchronous active-low reset.
- in_data  in  8  received byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block can accept a byte this cycle.
- mem_raddr  out  11  screen memory read address; memory returns mem_rdata one cycle later.
- mem_rdata  in  8  screen memory read data.
- mem_waddr  out  11  screen memory write address.
- mem_wdata  out  8  screen memory write data.
- mem_we  out  1  write strobe, one write per cycle.
- cur_row  out  5  cursor row, 0..ROWS-1.
- cur_col  out  7  cursor column, 0..COLS-1.
- busy  out  1  scroll or clear in progress.

Behaviour:
- Reset values (asynchronous on clr_n low): all outputs 0, except in_ready=0 until the first clk edge after release, then 1. State=IDLE. Reset mid-scroll aborts immediately; memory contents are left as they are.
- Memory address is row*COLS+col, computed as 11-bit unsigned.
- Handshake: a byte is accepted on a clk edge where in_valid && in_ready. in_ready is registered.
- After an accept, in_ready drops for exactly 1 cycle (IDLE) or until the operation ends (SCROLL/CLEAR).
- Maximum throughput is 1 byte per 2 cycles.

Byte decoding (one case per accepted byte):
- Printable byte (0x20-0x7E or 0xA0-0xFF):
  - The cycle after the accept has mem_we=1, mem_waddr=address(cur_row,cur_col), mem_wdata=byte.
  - cur_col increments at the same edge.
  - At col COLS-1 there is no autowrap: the character overwrites col 79 and the cursor stays at col 79.
- CR (0x0D): cur_col=0. No write.
- BS (0x08): cur_col decrements if >0; stays at 0 otherwise. No write.
- TAB (0x09): cur_col = next multiple of 8, saturating at COLS-1 (col 72 -> 79, col 79 -> 79).
- LF (0x0A):
  - If cur_row < ROWS-1: cur_row increments, no write.
  - If cur_row = ROWS-1: enter SCROLL; cursor is unchanged.
- FF (0x0C): enter CLEAR_ALL; the cursor goes to (0,0) when it completes.
- All other bytes: consumed, no effect.

State machine: IDLE, SCROLL, CLEAR_LINE, CLEAR_ALL.
- SCROLL:
  - busy=1 and in_ready=0.
  - Index i runs 0..1919. Cycle k drives mem_raddr=k+COLS for k=0..1919.
  - Cycle k+1 drives mem_we=1, mem_waddr=k, mem_wdata=mem_rdata.
  - Duration is 1921 cycles, then the state goes to CLEAR_LINE.
- CLEAR_LINE: 80 cycles writing BLANK to addresses 1920..1999 in order, then IDLE.
- CLEAR_ALL: 2000 cycles writing BLANK to addresses 0..1999 in order, then IDLE with cursor=(0,0).
- in_ready returns to 1 the cycle after the last write; busy falls in the same cycle.
- mem_we is never asserted outside the cases listed above.
- mem_raddr holds its last value when not in SCROLL.

Test Plan:
- Reset, then send 'A'(0x41) at (0,0): mem_we=1 one cycle later with waddr=0, wdata=0x41; cursor becomes (0,1); in_ready is low for 1 cycle.
- Cursor at (3,78), send 'x','y','z': writes go to addr 318, 319, 319 (no wrap); final cursor is (3,79).
- From (5,10) send TAB, BS, CR: cur_col steps 16 -> 15 -> 0; no writes occur.
- Preload memory with addr-derived data, cursor at (24,0), send LF:
  - busy stays high for 2001 cycles.
  - Memory addr n holds the old value of n+80 for n<1920; addrs 1920..1999 hold 0x20.
  - Cursor stays (24,0).
- Send FF at (12,40): 2000 writes of 0x20 to addrs 0..1999; cursor becomes (0,0); in_valid held high during this time is not accepted until in_ready returns.
- Pulse clr_n low midway through a scroll: outputs immediately read 0, mem_we deasserts, and the state is IDLE after release.
